load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Datapath-side consumer of the decoder's memory controls: MemRead, MemWrite, HWsig, ByteSig, SignSig.
// - Runs one load or store of byte, halfword or word size over a byte-wide req/ack memory port.
// - Stores transfer lanes 0..N-1 of a 32-bit word; loads reassemble the bytes and sign- or zero-extend them.
// - Stalls the core through busy. Sits between the register-file/ALU path and data memory.
// PARAMETERS
// - TIMEOUT  16  cycles without mem_ack before a transfer aborts with err (>=2).
// PORTS
// clk        in   1   single clock; all state changes on rising edge
// rst_n      in   1   synchronous active-low reset
// start      in   1   one-cycle command strobe; sampled only in IDLE
// MemRead    in   1   load command
// MemWrite   in   1   store command
// HWsig      in   1   halfword access
// ByteSig    in   1   byte access (priority over HWsig)
// SignSig    in   1   sign-extend byte/half load (ignored for word and store)
// addr       in   32  byte address from ALU
// wdata      in   32  store data (little-endian lanes)
// busy       out  1   high from cycle after accepted start until done cycle inclusive
// done       out  1   one-cycle completion pulse
// err        out  1   valid with done: misaligned, illegal command or timeout
// rdata      out  32  load result; holds until next successful load
// mem_req    out  1   byte transfer request
// mem_we     out  1   1 = write byte, 0 = read byte
// mem_addr   out  32  byte address of current lane
// mem_wdata  out  8   write byte
// mem_rdata  in   8   read byte, valid when mem_ack
// mem_ack    in   1   transfer complete this cycle (may arrive same cycle as mem_req)
// BEHAVIOUR
// - Reset: state IDLE; busy, done, err, mem_req, mem_we = 0; rdata, mem_addr, mem_wdata = 0; counters 0.
// - Size: ByteSig -> 1 byte; else HWsig -> 2 bytes; else 4 bytes.
// - FSM IDLE -> (start) CHECK -> XFER -> DONE -> IDLE. CHECK -> DONE directly on error.
//   - CHECK errors (no memory traffic):
//     - MemRead==MemWrite;
//     - half with addr[0]=1;
//     - word with addr[1:0]!=0.
// - XFER:
//   - mem_req is held high continuously. mem_addr = base+lane. mem_we = MemWrite.
//   - mem_wdata = wdata[8*lane+7 -: 8].
//   - On mem_ack: capture mem_rdata into lane buffer; lane advances and address/data update next cycle.
//   - The last ack drops mem_req next cycle and enters DONE.
// - Command fields are latched at start; input changes while busy are ignored, and start while busy is ignored.
// - DONE: done=1 for exactly one cycle.
//   - Successful load: rdata = assembled value, extended per latched SignSig.
//   - Store or error: rdata unchanged.
// - Latency with zero-wait memory (start at cycle 0):
//   - CHECK is cycle 1; mem_req runs cycles 2..1+N; done on cycle 2+N.
//   - Word op: done at cycle 6. Error op: done at cycle 2.
// - Timeout: wait counter resets on each ack. After TIMEOUT consecutive cycles in XFER with no ack, drop mem_req and go to DONE with err=1.
//   - Bytes already written by a partial store remain written.
// - rst_n low mid-transfer: mem_req=0 and IDLE at the next edge; no done pulse.
// STRUCTURE
// - Shared package/header: size encoding SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2; FSM state encoding; default TIMEOUT.
// - One sub-module: lsu_byte_assemble (combinational: lane buffer + size + sign -> 32-bit extended result).
// - Top holds FSM, lane counter (2 bits), wait counter ($clog2(TIMEOUT+1) bits), latched command.
// TESTING
// - Signed byte load: memory byte 0x80 at 0x103, zero-wait.
//   -> one req at 0x103; done at cycle 3; rdata=0xFFFFFF80; err=0.
// - Unsigned half load: bytes 0x34,0x12 at 0x200/0x201, SignSig=0, ack delayed 2 cycles each.
//   -> rdata=0x00001234; done at cycle 8.
// - Word store: wdata=0xDEADBEEF to 0x40.
//   -> writes EF,BE,AD,DE to 0x40..0x43 in order; done at cycle 6; rdata unchanged.
// - Misaligned word (addr=0x42), and MemRead=MemWrite=1.
//   -> no mem_req; done+err at cycle 2.
// - Timeout: word load, ack only for lane 0, TIMEOUT=16.
//   -> mem_req drops and done+err occur 16 cycles after the lane-0 ack; rdata unchanged.
// - Reset mid-transfer (rst_n low during lane 2 of a word store).
//   -> mem_req=0 next edge, no done; a new byte load after reset completes correctly.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : load_store_unit_pkg                                            |
// | Desc   : Shared size/state encodings and command record for the LSU.    |
// | Rev    : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int LSU_TIMEOUT_DEFAULT = 16;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_cmd_t;

  // ByteSig wins over HWsig; neither means a full word.
  function automatic logic [1:0] size_decode(input logic byte_sig, input logic hw_sig);
    if (byte_sig)    return SZ_BYTE;
    else if (hw_sig) return SZ_HALF;
    else             return SZ_WORD;
  endfunction

  function automatic logic [1:0] last_lane(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_assemble.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : lsu_byte_assemble                                              |
// | Desc   : Lane buffer + size + sign -> 32-bit extended load result.      |
// | Rev    : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
module lsu_byte_assemble
  import load_store_unit_pkg::*;
(
  input  logic [31:0] i_lanes,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  logic w_bfill;
  logic w_hfill;

  assign w_bfill = i_sign & i_lanes[7];
  assign w_hfill = i_sign & i_lanes[15];

  always_comb begin
    o_data = i_lanes;
    case (i_size)
      SZ_BYTE: o_data = {{24{w_bfill}}, i_lanes[7:0]};
      SZ_HALF: o_data = {{16{w_hfill}}, i_lanes[15:0]};
      default: o_data = i_lanes;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : load_store_unit                                                |
// | Desc   : Byte/half/word load-store sequencer over a byte-wide req/ack   |
// |          memory port, with alignment checks and an ack timeout.         |
// | Rev    : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        HWsig,
  input  logic        ByteSig,
  input  logic        SignSig,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  localparam int                c_wait_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);

  logic [1:0]          r_state;
  lsu_cmd_t            r_cmd;
  logic [1:0]          r_lane;
  logic [1:0]          r_last;
  logic [c_wait_w-1:0] r_wait;
  logic                r_err;
  logic [31:0]         r_rdata;
  logic [31:0]         r_buf;

  logic [31:0]         w_lanes;
  logic [31:0]         w_ext;
  logic                w_cmd_err;

  assign w_cmd_err = (r_cmd.rd == r_cmd.wr)
                   | ((r_cmd.size == SZ_HALF) & r_cmd.addr[0])
                   | ((r_cmd.size == SZ_WORD) & (r_cmd.addr[1:0] != 2'b00));

  // Merge the byte arriving this cycle so the final ack can commit rdata directly.
  always_comb begin
    w_lanes = r_buf;
    w_lanes[{r_lane, 3'b000} +: 8] = mem_rdata;
  end

  lsu_byte_assemble u_assemble (
    .i_lanes (w_lanes),
    .i_size  (r_cmd.size),
    .i_sign  (r_cmd.sign),
    .o_data  (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cmd   <= '0;
      r_lane  <= 2'd0;
      r_last  <= 2'd0;
      r_wait  <= '0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_buf   <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cmd.rd    <= MemRead;
            r_cmd.wr    <= MemWrite;
            r_cmd.size  <= size_decode(ByteSig, HWsig);
            r_cmd.sign  <= SignSig;
            r_cmd.addr  <= addr;
            r_cmd.wdata <= wdata;
            r_last      <= last_lane(size_decode(ByteSig, HWsig));
            r_lane      <= 2'd0;
            r_wait      <= '0;
            r_err       <= 1'b0;
            r_state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_cmd_err) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (mem_ack) begin
            r_buf  <= w_lanes;
            r_wait <= '0;
            if (r_lane == r_last) begin
              if (r_cmd.rd) begin
                r_rdata <= w_ext;
              end
              r_state <= ST_DONE;
            end else begin
              r_lane <= r_lane + 2'd1;
            end
          end else if (r_wait == c_wait_last) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = done & r_err;
  assign rdata     = r_rdata;
  assign mem_req   = (r_state == ST_XFER);
  assign mem_we    = mem_req & r_cmd.wr;
  assign mem_addr  = r_cmd.addr + {30'd0, r_lane};
  assign mem_wdata = r_cmd.wdata[{r_lane, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_load_store_unit                                             |
// | Desc   : Table-driven self-checking bench with a byte-memory model.     |
// | Rev    : 1.0  initial release                                           |
// +------------------------------------------------------------------------+
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, HWsig = 1'b0, ByteSig = 1'b0, SignSig = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        busy, done, err, mem_req, mem_we, mem_ack;
  logic [31:0] rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        ack_r = 1'b0;
  logic [7:0]  rd_r = 8'd0;

  assign mem_ack   = ack_r;
  assign mem_rdata = rd_r;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .MemRead(MemRead), .MemWrite(MemWrite), .HWsig(HWsig), .ByteSig(ByteSig), .SignSig(SignSig),
    .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        rd, wr, hw, bt, sg;
    logic [31:0] a, wd;
    int          dly, lim;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat, exp_req;
  } vec_t;

  vec_t        tbl [18];
  logic [7:0]  mem [0:4095];
  logic [39:0] wr_log [$];
  logic [39:0] exp_wr [$];
  int          ack_delay = 0, ack_limit = 0, acks = 0, wait_cnt = 0, req_cycles = 0;
  int          checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle; the memory model answers mem_req for the cycle just begun.
  task automatic tick();
    @(negedge clk);
    ack_r = 1'b0;
    rd_r  = 8'($urandom);
    if (mem_req) begin
      req_cycles++;
      if (wait_cnt >= ack_delay && acks < ack_limit) begin
        ack_r    = 1'b1;
        rd_r     = mem[mem_addr[11:0]];
        acks++;
        wait_cnt = 0;
        if (mem_we) begin
          mem[mem_addr[11:0]] = mem_wdata;
          wr_log.push_back({mem_addr, mem_wdata});
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic run_op(input int idx);
    vec_t        v;
    int          n, done_k, req_base;
    logic [31:0] rd_at_done;
    logic        err_at_done;
    logic [39:0] a_e, a_o;
    v = tbl[idx];
    n = v.bt ? 1 : (v.hw ? 2 : 4);
    if (v.wr && !v.rd && !v.exp_err)
      for (int i = 0; i < n; i++)
        exp_wr.push_back({v.a + 32'(i), v.wd[8*i +: 8]});
    ack_delay = v.dly;
    ack_limit = acks + v.lim;
    req_base  = req_cycles;
    MemRead = v.rd; MemWrite = v.wr; HWsig = v.hw; ByteSig = v.bt; SignSig = v.sg;
    addr = v.a; wdata = v.wd; start = 1'b1;
    done_k = -1; rd_at_done = 32'd0; err_at_done = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 1) begin
        start = 1'b0;
        chk($sformatf("v%0d busy_c1", idx), 64'(busy), 64'd1);
        addr = ~addr; wdata = ~wdata; MemRead = ~MemRead; MemWrite = ~MemWrite;
        HWsig = ~HWsig; ByteSig = ~ByteSig; SignSig = ~SignSig;
      end
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (done_k >= 0 && k == done_k + 1) begin
        chk($sformatf("v%0d done_width", idx), 64'(done), 64'd0);
        chk($sformatf("v%0d busy_after", idx), 64'(busy), 64'd0);
        break;
      end
      if (done && done_k < 0) begin
        done_k = k; rd_at_done = rdata; err_at_done = err;
      end
    end
    start = 1'b0;
    if (done_k < 0) begin
      checks++; failures++;
      $display("FAIL v%0d no_done: got none expected done at cycle %0d", idx, v.exp_lat);
    end else begin
      chk($sformatf("v%0d latency", idx), 64'(done_k), 64'(v.exp_lat));
      chk($sformatf("v%0d err", idx), 64'(err_at_done), 64'(v.exp_err));
      chk($sformatf("v%0d rdata", idx), 64'(rd_at_done), 64'(v.exp_rdata));
    end
    chk($sformatf("v%0d req_cycles", idx), 64'(req_cycles - req_base), 64'(v.exp_req));
    chk($sformatf("v%0d wr_count", idx), 64'(wr_log.size()), 64'(exp_wr.size()));
    while (exp_wr.size() > 0 && wr_log.size() > 0) begin
      a_e = exp_wr.pop_front();
      a_o = wr_log.pop_front();
      chk($sformatf("v%0d wr_byte", idx), 64'(a_o), 64'(a_e));
    end
    exp_wr.delete();
    wr_log.delete();
  endtask

  initial begin
    //           rd    wr    hw    bt    sg    addr       wdata         dly lim exp_rdata      err  lat req
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0,        0, 99, 32'hFFFFFF80, 1'b0, 3,  1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0,        2, 99, 32'h00001234, 1'b0, 8,  6};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h040, 32'hDEADBEEF, 0, 99, 32'h00001234, 1'b0, 6,  4};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h042, 32'h0,        0, 99, 32'h00001234, 1'b1, 2,  0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h040, 32'h0,        0, 99, 32'h00001234, 1'b1, 2,  0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h040, 32'h0,        0, 99, 32'h00001234, 1'b1, 2,  0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h201, 32'h0,        0, 99, 32'h00001234, 1'b1, 2,  0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h040, 32'h0,        0, 99, 32'hDEADBEEF, 1'b0, 6,  4};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h042, 32'h0,        0, 99, 32'hFFFFDEAD, 1'b0, 4,  2};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h105, 32'h00000055, 0, 99, 32'hFFFFDEAD, 1'b0, 3,  1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h105, 32'h0,        0, 99, 32'h00000055, 1'b0, 3,  1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h103, 32'h0,        0, 99, 32'h00000080, 1'b0, 3,  1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h040, 32'h0,        0, 99, 32'hDEADBEEF, 1'b0, 6,  4};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0000A5C3, 0, 99, 32'hDEADBEEF, 1'b0, 4,  2};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0,        1, 99, 32'hFFFFA5C3, 1'b0, 6,  4};
    // Lane 0 acked at cycle 2, then 16 silent request cycles before giving up.
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h040, 32'h0,        0, 1,  32'hFFFFA5C3, 1'b1, 19, 17};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h502, 32'h0,        0, 99, 32'h000000FE, 1'b0, 3,  1};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h503, 32'h0,        0, 99, 32'h00000000, 1'b0, 3,  1};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h103] = 8'h80;
    mem[12'h200] = 8'h34;
    mem[12'h201] = 8'h12;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        64'({busy, done, err, mem_req, mem_we, rdata, mem_addr, mem_wdata}), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) run_op(i);

    // Reset during lane 2 of a word store: lanes 0..2 land, lane 3 never does.
    ack_delay = 0;
    ack_limit = acks + 99;
    MemRead = 1'b0; MemWrite = 1'b1; HWsig = 1'b0; ByteSig = 1'b0; SignSig = 1'b0;
    addr = 32'h500; wdata = 32'hCAFEF00D; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    chk("rst_mid_lane2_addr", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h502}));
    rst_n = 1'b0;
    tick();
    chk("rst_mid_req_busy", 64'({mem_req, busy, done}), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_mid_no_done", 64'({done, busy, mem_req}), 64'd0);
    end
    wr_log.delete();
    run_op(16);
    run_op(17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
